// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 bus-timing engine and its upstream sequencer.
// Timing defaults are clk counts at 50 MHz.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC
  } lcd_state_t;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  localparam int LCD_T_SETUP     = 4;
  localparam int LCD_T_EN_HIGH   = 12;
  localparam int LCD_T_HOLD      = 2;
  localparam int LCD_T_EXEC      = 2500;
  localparam int LCD_T_EXEC_LONG = 82000;

  // 0x03 is also a return-home (bit 0 is don't-care), so it gets the long wait too.
  function automatic logic needs_long_exec(input logic rs, input logic [7:0] value);
    return !rs && ((value == CMD_CLEAR) || (value == CMD_HOME) || (value == (CMD_HOME | CMD_CLEAR)));
  endfunction

endpackage

// File: rtl/lcd_bus_writer_if.sv
// Byte request channel between the LCD sequencer (master) and the bus-timing engine (slave).
interface lcd_bus_writer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;

  modport master (output req_valid, output req_rs, output req_data, input req_ready);
  modport slave  (input req_valid, input req_rs, input req_data, output req_ready);
endinterface

// File: rtl/lcd_delay_counter.sv
// Down-counter shared by all timed states: load N-1 on state entry, expire reads high once it hits zero.
module lcd_delay_counter #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  // Saturates at zero so a long stay in IDLE can never wrap the counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/lcd_bus_writer.sv
// HD44780 write engine: turns one accepted byte into setup/enable/hold/exec bus timing.
// Define LCD_BUS_4BIT_EN for a 4-bit bus (two strobes per byte on lcd_data[7:4]).
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int T_SETUP     = LCD_T_SETUP,
  parameter int T_EN_HIGH   = LCD_T_EN_HIGH,
  parameter int T_HOLD      = LCD_T_HOLD,
  parameter int T_EXEC      = LCD_T_EXEC,
  parameter int T_EXEC_LONG = LCD_T_EXEC_LONG
) (
  input  logic              clk,
  input  logic              reset,
  lcd_bus_writer_if.slave   req,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_en,
  output logic [7:0]        lcd_data
);

  localparam int CNT_W = $clog2(T_EXEC_LONG + 1);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_EN_HIGH - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_EXEC_LONG - 1);

  lcd_state_t       state;
  lcd_state_t       next_state;
  logic             ready;
  logic             accept;
  logic             load;
  logic             expire;
  logic             long_exec;
  logic [CNT_W-1:0] load_value;
  logic [7:0]       exec_byte;

`ifdef LCD_BUS_4BIT_EN
  logic [7:0] cur_byte;
  logic       nibble;
  logic       nibble_switch;
  assign exec_byte = cur_byte;
`else
  assign exec_byte = lcd_data;
`endif

  assign req.req_ready = ready;
  assign lcd_rw        = 1'b0;
  assign accept        = (state == IDLE) && req.req_valid && ready;
  assign long_exec     = needs_long_exec(lcd_rs, exec_byte);

  lcd_delay_counter #(
    .WIDTH (CNT_W)
  ) delay (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .expire     (expire)
  );

  always_comb begin
    next_state = state;
`ifdef LCD_BUS_4BIT_EN
    nibble_switch = 1'b0;
`endif
    case (state)
      IDLE:  if (accept) next_state = SETUP;
      SETUP: if (expire) next_state = PULSE;
      PULSE: if (expire) next_state = HOLD;
      HOLD: begin
        if (expire) begin
`ifdef LCD_BUS_4BIT_EN
          if (!nibble) begin
            next_state    = SETUP;
            nibble_switch = 1'b1;
          end else begin
            next_state = EXEC;
          end
`else
          next_state = EXEC;
`endif
        end
      end
      EXEC:    if (expire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Every state change reloads the shared counter with the dwell of the state being entered.
  always_comb begin
    load       = (next_state != state);
    load_value = '0;
    case (next_state)
      SETUP:   load_value = LD_SETUP;
      PULSE:   load_value = LD_PULSE;
      HOLD:    load_value = LD_HOLD;
      EXEC:    load_value = long_exec ? LD_LONG : LD_EXEC;
      default: load_value = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Registered outputs; lcd_en clears asynchronously with reset so an aborted strobe ends at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready    <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
`ifdef LCD_BUS_4BIT_EN
      cur_byte <= 8'h00;
      nibble   <= 1'b0;
`endif
    end else begin
      ready  <= (next_state == IDLE);
      lcd_en <= (next_state == PULSE);
      if (accept) begin
        lcd_rs <= req.req_rs;
`ifdef LCD_BUS_4BIT_EN
        cur_byte <= req.req_data;
        lcd_data <= {req.req_data[7:4], 4'h0};
        nibble   <= 1'b0;
      end else if (nibble_switch) begin
        lcd_data <= {cur_byte[3:0], 4'h0};
        nibble   <= 1'b1;
`else
        lcd_data <= req.req_data;
`endif
      end
    end
  end

endmodule
